// File: rtl/if_id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// if_id_hazard_ctrl
// Front-end pipeline controller for a 5-stage MIPS core. It decides, every
// cycle, whether the PC and IF/ID register advance, whether IF/ID is flushed,
// and whether a bubble goes into ID/EX. It covers three situations:
// load-use stalls, taken branch/jump redirects (with a programmable flush
// window) and instruction-memory wait states.
//
// Ports:
//   i_clk            clock, all state changes on the rising edge
//   i_reset          synchronous active-high reset
//   i_id_rs          rs field of the instruction in ID
//   i_id_rt          rt field of the instruction in ID
//   i_id_uses_rt     ID instruction reads rt as a source
//   i_id_ex_mem_read instruction in EX is a load
//   i_id_ex_rt       destination rt of the instruction in EX
//   i_redirect       branch taken / jump resolved in ID this cycle
//   i_imem_ready     instruction memory returns valid data this cycle
//   o_pc_write       PC load enable
//   o_if_id_write    IF/ID write enable
//   o_if_id_flush    IF/ID flush
//   o_id_ex_flush    bubble into ID/EX
//   o_state          FSM state: RUN=0, WAIT=1, FLUSH=2 (registered)
//   o_stall_cycles   saturating count of cycles with o_pc_write=0 (registered)
//   o_imem_timeout   sticky instruction-memory timeout flag (registered)
// -----------------------------------------------------------------------------
module if_id_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,    // legal 1..15
    parameter int WAIT_TIMEOUT = 255,  // legal 1..255
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_ex_mem_read,
    input  logic [4:0]       i_id_ex_rt,
    input  logic             i_redirect,
    input  logic             i_imem_ready,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic             o_imem_timeout
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_UNUSED = 2'd3;

    // The redirect cycle itself is the first flush cycle, so FLUSH state
    // only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       WAIT_MAX   = 8'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [3:0]       r_flush_cnt;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             r_imem_timeout;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_flush_cnt_nxt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             w_load_use;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;

    // Register 0 is hard-wired to zero, so a load targeting it never hazards.
    assign w_load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                        ((i_id_ex_rt == i_id_rs) ||
                         (i_id_uses_rt && (i_id_ex_rt == i_id_rt)));

    // State register plus the flush-window and wait counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        case (r_state)
            ST_FLUSH: begin
                // The window only advances on cycles that actually deliver
                // an instruction; redirect and load-use are ignored here.
                if (i_imem_ready) begin
                    if (r_flush_cnt <= 4'd1) begin
                        w_state_nxt     = ST_RUN;
                        w_flush_cnt_nxt = 4'd0;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt;
                end
            end
            default: begin
                // RUN, WAIT and the unused encoding share the priority chain.
                if (w_load_use) begin
                    // Branch operands are not ready, so a coincident
                    // redirect is dropped; the bubble is re-evaluated
                    // next cycle.
                    w_state_nxt = (r_state == ST_WAIT) ? ST_WAIT : ST_RUN;
                end else if (i_redirect) begin
                    w_wait_cnt_nxt = 8'd0;
                    if (FLUSH_CYCLES == 1) begin
                        w_state_nxt     = ST_RUN;
                        w_flush_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_LOAD;
                    end
                end else if (!i_imem_ready) begin
                    w_state_nxt = ST_WAIT;
                    if (r_wait_cnt < WAIT_MAX) begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt;
                    end
                end else begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
                // The unused encoding always recovers to RUN.
                if (r_state == ST_UNUSED) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = w_state_nxt;
                end
            end
        endcase
    end

    // Control outputs, combinational from state and hazard inputs.
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (i_reset) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_pc_write    = i_imem_ready;
                    w_if_id_write = i_imem_ready;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b0;
                end
                default: begin
                    if (w_load_use || (!i_redirect && !i_imem_ready)) begin
                        // Freeze front end, bubble into ID/EX.
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_if_id_flush = 1'b0;
                        w_id_ex_flush = 1'b1;
                    end else if (i_redirect) begin
                        // Load the target and squash the wrong-path fetch.
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b0;
                    end else begin
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                        w_if_id_flush = 1'b0;
                        w_id_ex_flush = 1'b0;
                    end
                end
            endcase
        end
    end

    // Stall statistics and the sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_imem_timeout <= 1'b0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (w_wait_cnt_nxt == WAIT_MAX) begin
                r_imem_timeout <= 1'b1;
            end else begin
                r_imem_timeout <= r_imem_timeout;
            end
        end
    end

    assign o_pc_write     = w_pc_write;
    assign o_if_id_write  = w_if_id_write;
    assign o_if_id_flush  = w_if_id_flush;
    assign o_id_ex_flush  = w_id_ex_flush;
    assign o_state        = r_state;
    assign o_stall_cycles = r_stall_cycles;
    assign o_imem_timeout = r_imem_timeout;

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
Front-end pipeline controller for the 5-stage MIPS core. It drives the PC write enable and the IF/ID write and flush controls, plus the ID/EX flush. It sequences:
- load-use stalls,
- taken-branch/jump redirects with a programmable flush window,
- instruction-memory wait states.

It sits between the hazard inputs (ID/EX stage fields, branch unit, instruction memory) and the PC, IF_ID and ID_EX registers.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles if_id_flush is held after a redirect (legal 1..15)
WAIT_TIMEOUT, 255, consecutive imem-not-ready cycles after which imem_timeout is set (legal 1..255)
CNT_W, 16, width of the stall_cycles counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
id_ex_mem_read  input  1  instruction in EX is a load
id_ex_rt  input  5  destination rt of instruction in EX
redirect  input  1  branch taken or jump resolved in ID this cycle
imem_ready  input  1  instruction memory returns valid data this cycle
pc_write  output  1  PC load enable (1 = load next PC)
if_id_write  output  1  IF_ID write enable, 1 = IF_ID_WRITE_ON
if_id_flush  output  1  IF_ID flush, 1 = IF_ID_FLUSH_ON
id_ex_flush  output  1  insert bubble into ID/EX
state  output  2  FSM state: RUN=0, WAIT=1, FLUSH=2
stall_cycles  output  CNT_W  count of cycles with pc_write=0
imem_timeout  output  1  sticky instruction-memory timeout flag

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high. All registers clear only on a clk edge with reset=1.
- Output timing:
  - Control outputs are combinational from the state register and the inputs.
  - state, stall_cycles and imem_timeout are registered.
- While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
- After reset: state=RUN, flush counter=0, wait counter=0, stall_cycles=0, imem_timeout=0.
- Load-use: load_use = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==id_rs) | (id_uses_rt & id_ex_rt==id_rt)).
- Output sets:
  - FREEZE: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
  - NORMAL: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0.
- Priority in RUN and WAIT: load_use > redirect > !imem_ready > normal.
  - load_use: FREEZE; state unchanged; wait counter unchanged. Bubble is 1 cycle per occurrence, re-evaluated every cycle. A simultaneous redirect is ignored (branch operands not ready).
  - redirect: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0. Any outstanding fetch is discarded and the wait counter is cleared.
    - FLUSH_CYCLES=1: next state RUN.
    - Otherwise: next state FLUSH, flush counter loaded with FLUSH_CYCLES-1.
  - !imem_ready: FREEZE; next state WAIT; wait counter increments, saturating at WAIT_TIMEOUT.
  - imem_ready (no hazard): NORMAL; next state RUN; wait counter cleared. WAIT exits in the same cycle ready rises, with no extra bubble.
- FLUSH state:
  - Outputs: if_id_flush=1, id_ex_flush=0, pc_write=imem_ready, if_id_write=imem_ready.
  - redirect and load_use are ignored.
  - Counter decrements only when imem_ready=1. When it is 1 and imem_ready=1, next state is RUN.
- imem_timeout:
  - Set on the edge where the wait counter reaches WAIT_TIMEOUT.
  - Stays set (sticky) until reset.
  - Has no effect on the control outputs.
- stall_cycles:
  - Increments on every non-reset cycle with pc_write=0.
  - Saturates at all-ones and never wraps.
- Reset mid-operation (in WAIT or FLUSH): next state RUN, all counters cleared, and the pending flush window is abandoned.
- Unused state encoding 3: treated as RUN and driven to RUN on the next edge.

Test Plan:
- Reset for 2 cycles, then idle with imem_ready=1 -> outputs NORMAL (1,1,0,0), state=0, stall_cycles=0, imem_timeout=0.
- id_ex_mem_read=1, id_ex_rt=8, id_rs=8 for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles=1. Same with id_ex_rt=0 -> no stall.
- FLUSH_CYCLES=3, redirect pulse of 1 cycle -> if_id_flush=1 for exactly 3 cycles, state sequence RUN,FLUSH,FLUSH,RUN. With imem_ready=0 during the second flush cycle -> window extends to 4 cycles.
- imem_ready=0 for 5 cycles, then 1 -> 5 FREEZE cycles, state=WAIT, stall_cycles=5, NORMAL on the ready cycle, state=RUN next cycle.
- load_use and redirect asserted together -> FREEZE, no if_id_flush. Redirect alone next cycle -> flush.
- WAIT_TIMEOUT=4, imem_ready=0 for 6 cycles -> imem_timeout=1 after 4th cycle and held after ready returns. Apply reset while in WAIT -> state=0, imem_timeout=0, stall_cycles=0.
